// File: rtl/i2c_gpio_master.sv
// i2c_gpio_master
// Single-byte I2C master driving open-drain pads through output enables.
// One command performs START, address + R/W, address ACK, one data byte,
// data ACK and STOP, then pulses rsp_valid for one clock.
//
// Ports:
//   clk, reset          system clock (rising edge), async active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_addr/rw/wdata   7-bit slave address, 1 = read, write byte
//   rsp_valid           one-clock completion pulse
//   rsp_rdata/rsp_nack  read byte and NACK flag, held until next accept
//   busy                high whenever a transaction is in progress
//   scl_oe/sda_oe       1 pulls the line low, 0 releases it
//   scl_in/sda_in       asynchronous pad levels
module i2c_gpio_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
    } state_t;

    localparam logic [15:0] QLAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d;
    logic        sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;

    logic        in_slot, stall, quarter_end, slot_end;
    logic [7:0]  addr_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            phase_q    <= '0;
            bitcnt_q   <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            nack_q     <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            phase_q    <= phase_d;
            bitcnt_q   <= bitcnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            nack_q     <= nack_d;
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        phase_d    = phase_q;
        bitcnt_d   = bitcnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        nack_d     = nack_q;
        scl_meta_d = scl_in;
        scl_sync_d = scl_meta_q;
        sda_meta_d = sda_in;
        sda_sync_d = sda_meta_q;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        addr_byte  = {addr_q, rw_q};

        in_slot = (state_q != S_IDLE) && (state_q != S_DONE);

        // SCL is released at the start of q2, but the synchroniser needs two
        // clocks to show it high. The first two counts of q2 therefore run
        // unconditionally and the stretch check is made at count 2, so an
        // unheld SCL costs nothing and a held one delays by exactly the hold.
        stall       = in_slot && (phase_q == 2'd2) && (qcnt_q == 16'd2) && !scl_sync_q;
        quarter_end = in_slot && !stall && (qcnt_q == QLAST);
        slot_end    = quarter_end && (phase_q == 2'd3);

        if (in_slot && !stall) begin
            if (quarter_end) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rw_d    = cmd_rw;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    nack_d  = 1'b0;
                    qcnt_d  = '0;
                    phase_d = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                sda_oe = phase_q[1];
                if (slot_end) begin
                    bitcnt_d = 3'd7;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                scl_oe = ~phase_q[1];
                sda_oe = ~addr_byte[bitcnt_q];
                if (slot_end) begin
                    if (bitcnt_q == 3'd0) state_d = S_AACK;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
            end
            S_AACK: begin
                scl_oe = ~phase_q[1];
                if (slot_end) begin
                    // Nobody answered the address: skip the data byte entirely.
                    if (sda_sync_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bitcnt_d = 3'd7;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                scl_oe = ~phase_q[1];
                sda_oe = ~rw_q & ~wdata_q[bitcnt_q];
                if (slot_end) begin
                    if (rw_q) rdata_d = {rdata_q[6:0], sda_sync_q};
                    if (bitcnt_q == 3'd0) state_d = S_DACK;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
            end
            S_DACK: begin
                // On a read the master leaves SDA released, i.e. NACKs the
                // single byte so the slave stops sending.
                scl_oe = ~phase_q[1];
                if (slot_end) begin
                    if (!rw_q && sda_sync_q) nack_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                scl_oe = ~phase_q[1];
                sda_oe = (phase_q != 2'd3);
                if (slot_end) state_d = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;

endmodule

// File: tb/tb_i2c_gpio_master.sv
module tb_i2c_gpio_master;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe, sda_oe;
    logic       scl_in, sda_in;

    int total = 0;
    int bad = 0;

    // Bus / slave model state
    logic       slave_present = 1'b1;
    logic [7:0] slave_rdata = 8'h00;
    logic       stretch_en = 1'b0;
    logic       stretch_armed = 1'b0;
    int         stretch_cnt = 0;
    logic       slave_pull = 1'b0;
    logic       in_frame = 1'b0;
    int         slot = -1;
    int         stop_cnt = 0;
    logic [7:0] mon_addr = '0;
    logic [7:0] mon_data = '0;
    logic       mon_aack = 1'b1;
    logic       mon_dack = 1'b1;
    logic       scl_prev = 1'b1, sda_prev = 1'b1, scl_oe_prev = 1'b0;
    logic       scl_now, sda_now;

    always #5 clk = ~clk;

    assign scl_in = ~(scl_oe | (stretch_cnt != 0));
    assign sda_in = ~(sda_oe | slave_pull);

    i2c_gpio_master #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_in(scl_in), .sda_in(sda_in)
    );

    // Slave and bus observer, evaluated mid-cycle on the falling clock edge.
    // Detects START/STOP, numbers bit slots by SCL falling edges, records
    // SDA at SCL rising edges, drives ACK/read data, and stretches SCL in q2
    // of address bit slot 3 when enabled.
    always @(negedge clk) begin
        if (stretch_cnt > 0) stretch_cnt = stretch_cnt - 1;
        if (stretch_armed && in_frame && slot == 3 && scl_oe_prev && !scl_oe) begin
            stretch_cnt   = 20;
            stretch_armed = 1'b0;
        end
        scl_now = !(scl_oe || stretch_cnt != 0);
        sda_now = !(sda_oe || slave_pull);
        if (reset) begin
            in_frame    = 1'b0;
            slave_pull  = 1'b0;
            stretch_cnt = 0;
        end else if (scl_prev && scl_now && sda_prev && !sda_now) begin
            in_frame      = 1'b1;
            slot          = -1;
            mon_addr      = '0;
            mon_data      = '0;
            stretch_armed = stretch_en;
        end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
            in_frame   = 1'b0;
            slave_pull = 1'b0;
            stop_cnt   = stop_cnt + 1;
        end else if (in_frame) begin
            if (scl_prev && !scl_now) begin
                slot = slot + 1;
                if (slot == 8)
                    slave_pull = slave_present;
                else if (slot >= 9 && slot <= 16)
                    slave_pull = mon_addr[0] && slave_present && !slave_rdata[16 - slot];
                else if (slot == 17)
                    slave_pull = !mon_addr[0] && slave_present;
                else
                    slave_pull = 1'b0;
            end
            if (!scl_prev && scl_now) begin
                if (slot >= 0 && slot <= 7)       mon_addr = {mon_addr[6:0], sda_now};
                else if (slot == 8)               mon_aack = sda_now;
                else if (slot >= 9 && slot <= 16) mon_data = {mon_data[6:0], sda_now};
                else if (slot == 17)              mon_dack = sda_now;
            end
        end
        scl_prev    = scl_now;
        sda_prev    = !(sda_oe || slave_pull);
        scl_oe_prev = scl_oe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one command, optionally pulses a second command while busy or
    // asserts reset at a given cycle, and returns the accept-to-rsp_valid
    // latency (accept edge = cycle 1) plus the response fields.
    task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] w,
                                 input int pulse_at, input int reset_at,
                                 output int lat, output logic [7:0] rd, output logic nk);
        int cyc;
        lat = -1;
        rd  = '0;
        nk  = 1'b0;
        @(negedge clk);
        cmd_addr  = a;
        cmd_rw    = r;
        cmd_wdata = w;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_rw    = ~r;
        cmd_wdata = ~w;
        cyc = 1;
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        checkOutput("ready_after_accept", {31'd0, cmd_ready}, 32'd0);
        while (cyc < 2000) begin
            if (rsp_valid) begin
                lat = cyc;
                rd  = rsp_rdata;
                nk  = rsp_nack;
                break;
            end
            if (cyc == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
                checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
                checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                reset = 1'b0;
                lat = 0;
                return;
            end
            if (cyc == pulse_at) begin
                cmd_valid = 1'b1;
                cmd_addr  = 7'h2A;
                cmd_rw    = 1'b1;
            end else if (cyc == pulse_at + 1) begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (lat < 0) checkOutput("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rsp_one_clk", {31'd0, rsp_valid}, 32'd0);
        checkOutput("idle_after", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rdata_hold", {24'd0, rsp_rdata}, {24'd0, rd});
    endtask

    initial begin
        int lat;
        logic [7:0] rd;
        logic nk;
        int stops;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_scl_oe", {31'd0, scl_oe}, 32'd0);
        checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rdata", {24'd0, rsp_rdata}, 32'h00);
        checkOutput("reset_nack", {31'd0, rsp_nack}, 32'd0);

        // Write 0x00 / 0xA5, slave ACKs everything
        stops = stop_cnt;
        applyStimulus(7'h00, 1'b0, 8'hA5, -1, -1, lat, rd, nk);
        checkOutput("wr_latency", lat, 32'd321);
        checkOutput("wr_nack", {31'd0, nk}, 32'd0);
        checkOutput("wr_rdata", {24'd0, rd}, 32'h00);
        checkOutput("wr_addr_bits", {24'd0, mon_addr}, 32'h00);
        checkOutput("wr_data_bits", {24'd0, mon_data}, 32'hA5);
        checkOutput("wr_aack", {31'd0, mon_aack}, 32'd0);
        checkOutput("wr_dack", {31'd0, mon_dack}, 32'd0);
        checkOutput("wr_stop", stop_cnt - stops, 32'd1);

        // Read 0x00, slave returns 0x3C, master NACKs the byte
        slave_rdata = 8'h3C;
        applyStimulus(7'h00, 1'b1, 8'h00, -1, -1, lat, rd, nk);
        checkOutput("rd_latency", lat, 32'd321);
        checkOutput("rd_rdata", {24'd0, rd}, 32'h3C);
        checkOutput("rd_nack", {31'd0, nk}, 32'd0);
        checkOutput("rd_addr_bits", {24'd0, mon_addr}, 32'h01);
        checkOutput("rd_bus_data", {24'd0, mon_data}, 32'h3C);
        checkOutput("rd_master_nack", {31'd0, mon_dack}, 32'd1);

        // Write to 0x55 with no slave present: address NACK
        slave_present = 1'b0;
        stops = stop_cnt;
        applyStimulus(7'h55, 1'b0, 8'hFF, -1, -1, lat, rd, nk);
        checkOutput("nack_latency", lat, 32'd177);
        checkOutput("nack_flag", {31'd0, nk}, 32'd1);
        checkOutput("nack_rdata", {24'd0, rd}, 32'h00);
        checkOutput("nack_addr_bits", {24'd0, mon_addr}, 32'hAA);
        checkOutput("nack_stop", stop_cnt - stops, 32'd1);
        slave_present = 1'b1;

        // Clock stretch of 20 clks in q2 of address bit slot 3
        stretch_en = 1'b1;
        applyStimulus(7'h12, 1'b0, 8'hC3, -1, -1, lat, rd, nk);
        stretch_en = 1'b0;
        checkOutput("str_latency", lat, 32'd341);
        checkOutput("str_nack", {31'd0, nk}, 32'd0);
        checkOutput("str_addr_bits", {24'd0, mon_addr}, 32'h24);
        checkOutput("str_data_bits", {24'd0, mon_data}, 32'hC3);

        // Reset in the middle of a write, then a normal write
        applyStimulus(7'h33, 1'b0, 8'h77, -1, 100, lat, rd, nk);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        applyStimulus(7'h33, 1'b0, 8'h5A, -1, -1, lat, rd, nk);
        checkOutput("post_rst_latency", lat, 32'd321);
        checkOutput("post_rst_addr", {24'd0, mon_addr}, 32'h66);
        checkOutput("post_rst_data", {24'd0, mon_data}, 32'h5A);
        checkOutput("post_rst_nack", {31'd0, nk}, 32'd0);

        // Second command pulsed while busy must be ignored
        applyStimulus(7'h0F, 1'b0, 8'h81, 50, -1, lat, rd, nk);
        checkOutput("ign_latency", lat, 32'd321);
        checkOutput("ign_addr_bits", {24'd0, mon_addr}, 32'h1E);
        checkOutput("ign_data_bits", {24'd0, mon_data}, 32'h81);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ign_still_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_gpio_master.md
I2C_GPIO_MASTER -- requirements
Module: i2c_gpio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, clk cycles per SCL quarter-period (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  transaction request.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_addr  input  7  target 7-bit slave address.
REQ-007 SHALL have port cmd_rw  input  1  1 = single-byte read, 0 = single-byte write.
REQ-008 SHALL have port cmd_wdata  input  8  write byte.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  8  read byte, valid with rsp_valid.
REQ-011 SHALL have port rsp_nack  output  1  1 = address or write-data NACK, valid with rsp_valid.
REQ-012 SHALL have port busy  output  1  high whenever not IDLE.
REQ-013 SHALL have port scl_oe  output  1  1 pulls SCL low; 0 releases (open-drain).
REQ-014 SHALL have port sda_oe  output  1  1 pulls SDA low; 0 releases.
REQ-015 SHALL have port scl_in  input  1  SCL pad level, asynchronous.
REQ-016 SHALL have port sda_in  input  1  SDA pad level, asynchronous.

Function
REQ-017 SHALL capture cmd_addr, cmd_rw, cmd_wdata on accept; later input changes have no effect.
REQ-018 SHALL synchronise scl_in and sda_in through two flops before use.
REQ-019 SHALL sequence states IDLE -> START -> ADDR(8 bits incl. R/W) -> AACK -> DATA(8) -> DACK -> STOP -> DONE -> IDLE.
REQ-020 SHALL time every non-IDLE/DONE state slot as four quarters q0..q3 of CLK_DIV clks each, via a quarter counter and 2-bit phase.
REQ-021 START: q0-q1 SCL and SDA released; q2-q3 SDA low, SCL released.
REQ-022 Bit slot: q0-q1 SCL low, SDA set for the bit; q2-q3 SCL released; SDA unchanged during q2-q3.
REQ-023 SHALL stall q2 (clock stretching) until the synchronised SCL reads high, then start the q2 count; no extra stall when SCL not held.
REQ-024 SHALL sample synchronised SDA on the last clk of q3 of each bit slot.
REQ-025 ADDR SHALL send {addr[6:0], rw} MSB first; sda_oe = ~bit.
REQ-026 AACK/DACK on write: sda_oe = 0; sampled 1 = NACK.
REQ-027 Address NACK SHALL skip DATA/DACK, go to STOP, set rsp_nack = 1.
REQ-028 Read DATA: sda_oe = 0, sampled bits shift into rsp_rdata MSB first; DACK: master drives NACK (sda_oe = 0); rsp_nack = 0.
REQ-029 Write DATA: sends wdata MSB first; DACK sampled 1 sets rsp_nack = 1.
REQ-030 STOP: q0-q1 SCL low, SDA low; q2 SCL released, SDA low; q3 both released.
REQ-031 DONE SHALL last exactly one clk with rsp_valid = 1; rsp_rdata/rsp_nack hold until next accept.
REQ-032 Latency without stretching: rsp_valid exactly 80*CLK_DIV+1 clks after accept for full transfer, 44*CLK_DIV+1 on address NACK.
REQ-033 cmd_valid while busy SHALL be ignored (no queueing).
REQ-034 rsp_rdata SHALL be 8'h00 after a write or address NACK.

Reset
REQ-035 On reset: state IDLE, cmd_ready = 1, busy = 0, rsp_valid = 0, rsp_rdata = 8'h00, rsp_nack = 0, scl_oe = 0, sda_oe = 0, counters 0.
REQ-036 Reset mid-transaction SHALL release both lines immediately, with no STOP generated and no rsp_valid.

Verification
REQ-037 CLK_DIV=4, write addr 7'h00 data 8'hA5, slave ACKs all -> SDA bits 00000000 then 10100101, rsp_valid at clk 321, rsp_nack = 0.
REQ-038 CLK_DIV=4, read addr 7'h00, slave returns 8'h3C -> R/W bit 1, master NACK on DACK, rsp_rdata = 8'h3C, rsp_nack = 0.
REQ-039 CLK_DIV=4, write addr 7'h55, no slave -> STOP after AACK, rsp_valid at clk 177, rsp_nack = 1, rsp_rdata = 8'h00.
REQ-040 Slave holds SCL low 20 clks in q2 of bit 3 -> all later edges shift by exactly 20 clks, data intact.
REQ-041 Reset at clk 100 of a write -> next clk scl_oe = sda_oe = 0, busy = 0; new command then completes normally.
REQ-042 cmd_valid pulsed while busy with different addr -> ignored; bus traffic matches first command only.
